// File: rtl/sram_test_master.sv
// March-style SRAM tester: writes a seeded pattern over DEPTH words, reads it back,
// then repeats with the inverted pattern; counts mismatches and reports pass/fail.
module sram_test_master #(
    parameter int DEPTH  = 10240,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic              avm_clken,
    input  logic [31:0]       avm_readdata
);

    typedef enum logic [2:0] {IDLE, WR, RD, DRAIN, FIN} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                p_q;
    logic [31:0]         seed_q;
    logic                rd_vld_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [15:0]         err_q;
    logic [15:0]         err_d;
    logic [ADDR_W-1:0]   first_q;
    logic                pass_q;
    logic                done_q;
    logic                mismatch;

    function automatic logic [31:0] pattern(input logic [31:0] s,
                                            input logic [ADDR_W-1:0] a,
                                            input logic inv);
        logic [31:0] d;
        d = s ^ 32'(a);
        return inv ? ~d : d;
    endfunction

    // Read data returns one cycle after the read, so compare against the delayed address.
    assign mismatch = rd_vld_q && (avm_readdata != pattern(seed_q, rd_addr_q, p_q));
    assign err_d    = (mismatch && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            p_q       <= 1'b0;
            seed_q    <= '0;
            rd_vld_q  <= 1'b0;
            rd_addr_q <= '0;
            err_q     <= '0;
            first_q   <= '0;
            pass_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            rd_vld_q <= 1'b0;
            if (mismatch) begin
                err_q <= err_d;
                if (err_q == 16'd0) first_q <= rd_addr_q;
            end
            if (abort && (state_q == WR || state_q == RD || state_q == DRAIN)) begin
                state_q <= IDLE;
                addr_q  <= '0;
                p_q     <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start && !abort) begin
                            seed_q  <= seed;
                            err_q   <= '0;
                            first_q <= '0;
                            pass_q  <= 1'b0;
                            p_q     <= 1'b0;
                            addr_q  <= '0;
                            state_q <= WR;
                        end
                    end
                    WR: begin
                        addr_q <= addr_q + ADDR_W'(1);
                        if (addr_q == LAST) begin
                            addr_q  <= '0;
                            state_q <= RD;
                        end
                    end
                    RD: begin
                        rd_vld_q  <= 1'b1;
                        rd_addr_q <= addr_q;
                        addr_q    <= addr_q + ADDR_W'(1);
                        if (addr_q == LAST) begin
                            addr_q  <= '0;
                            state_q <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (!p_q) begin
                            p_q     <= 1'b1;
                            addr_q  <= '0;
                            state_q <= WR;
                        end else begin
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == 16'd0);
                            state_q <= FIN;
                        end
                    end
                    FIN: begin
                        p_q     <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy           = (state_q == WR) || (state_q == RD) || (state_q == DRAIN);
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = first_q;
    assign avm_chipselect = (state_q == WR) || (state_q == RD);
    assign avm_write      = (state_q == WR);
    assign avm_address    = avm_chipselect ? addr_q : '0;
    assign avm_writedata  = (state_q == WR) ? pattern(seed_q, addr_q, p_q) : 32'd0;
    assign avm_byteenable = 4'hF;
    assign avm_clken      = 1'b1;

endmodule

// File: tb/tb_sram_test_master.sv
// Bench for sram_test_master with a 16-word, 1-cycle-latency RAM model and fault injection.
module tb_sram_test_master;
    localparam int DEPTH = 16;
    localparam int AW    = 14;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start, abort;
    logic [31:0]   seed;
    logic          busy, done, pass;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr, avm_address;
    logic [3:0]    avm_byteenable;
    logic          avm_chipselect, avm_write, avm_clken;
    logic [31:0]   avm_writedata, avm_readdata;

    sram_test_master #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .avm_address(avm_address),
        .avm_byteenable(avm_byteenable), .avm_chipselect(avm_chipselect),
        .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_clken(avm_clken),
        .avm_readdata(avm_readdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RAM model; fault 1 = bit0 stuck-1 @5, 2 = reads return 0, 3 = bit31 stuck-0 @15
    logic [31:0] mem [DEPTH];
    int          fault = 0;
    always @(posedge clk) begin
        if (avm_chipselect && avm_write) mem[int'(avm_address[3:0])] <= avm_writedata;
        if (avm_chipselect && !avm_write) begin
            case (fault)
                1: avm_readdata <= (avm_address == 5)  ? (mem[5] | 32'h1) : mem[int'(avm_address[3:0])];
                2: avm_readdata <= 32'd0;
                3: avm_readdata <= (avm_address == 15) ? (mem[15] & 32'h7FFF_FFFF) : mem[int'(avm_address[3:0])];
                default: avm_readdata <= mem[int'(avm_address[3:0])];
            endcase
        end
    end

    typedef struct { logic [AW-1:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic [15:0] err; logic [AW-1:0] first; logic pass; } res_t;
    typedef struct {
        int          fault;
        logic [31:0] seed;
        int          start_at;
        logic [15:0] exp_err;
        logic [AW-1:0] exp_first;
        logic        exp_pass;
    } vec_t;

    wr_t         exp_wr[$];
    res_t        res_q[$];
    logic [31:0] wr3[$];
    bit          mon_en = 1'b0;

    function automatic logic [31:0] pat(input logic [31:0] s, input int a, input bit inv);
        logic [31:0] d;
        d = s ^ 32'(a);
        return inv ? ~d : d;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            chk("byteenable", {28'd0, avm_byteenable}, 32'hF);
            chk("clken", {31'd0, avm_clken}, 32'd1);
            if (!busy)
                chk("idle_bus", {avm_chipselect, avm_write, avm_address, avm_writedata != 32'd0},
                    '0);
            if (avm_chipselect && avm_write) begin
                if (avm_address == 3) wr3.push_back(avm_writedata);
                if (exp_wr.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
                else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    chk("wr_addr", 32'(avm_address), 32'(w.addr));
                    chk("wr_data", avm_writedata, w.data);
                end
            end
        end
    end

    task automatic push_writes(input logic [31:0] s);
        for (int p = 0; p < 2; p++)
            for (int a = 0; a < DEPTH; a++)
                exp_wr.push_back('{AW'(a), pat(s, a, p[0])});
    endtask

    task automatic run_test(input vec_t v);
        int bc = 0;
        int dc = 0;
        bit fin = 0;
        fault = v.fault;
        wr3.delete();
        push_writes(v.seed);
        res_q.push_back('{v.exp_err, v.exp_first, v.exp_pass});
        @(negedge clk);
        start = 1'b1;
        seed  = v.seed;
        for (int c = 0; c < 300 && !fin; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) bc++;
            if (v.start_at != 0 && bc == v.start_at) begin
                start = 1'b1;
                seed  = ~v.seed;
            end
            if (done) begin
                dc++;
                fin = 1;
                if (res_q.size() == 0) chk("res_queue_empty", 32'd1, 32'd0);
                else begin
                    res_t r;
                    r = res_q.pop_front();
                    chk("err_count", {16'd0, err_count}, {16'd0, r.err});
                    chk("first_err_addr", 32'(first_err_addr), 32'(r.first));
                    chk("pass", {31'd0, pass}, {31'd0, r.pass});
                end
            end
        end
        if (!fin) chk("done_timeout", 32'd0, 32'd1);
        repeat (3) begin
            @(negedge clk);
            if (done) dc++;
        end
        chk("busy_cycles", 32'(bc), 32'd66);
        chk("done_pulses", 32'(dc), 32'd1);
        chk("wr_leftover", 32'(exp_wr.size()), 32'd0);
        exp_wr.delete();
    endtask

    vec_t tbl[6];

    initial begin
        int bc;
        int dc;
        tbl[0] = '{0, 32'hA5A50000, 0, 16'd0,  AW'(0),  1'b1};
        tbl[1] = '{1, 32'hA5A50000, 0, 16'd1,  AW'(5),  1'b0};
        tbl[2] = '{2, 32'hA5A50000, 0, 16'd32, AW'(0),  1'b0};
        tbl[3] = '{0, 32'h12345678, 0, 16'd0,  AW'(0),  1'b1};
        tbl[4] = '{3, 32'hA5A50000, 0, 16'd1,  AW'(15), 1'b0};
        tbl[5] = '{0, 32'hDEADBEEF, 20, 16'd0, AW'(0),  1'b1};

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; seed = '0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_outs", {done, pass, err_count, avm_chipselect, avm_write}, '0);
        chk("rst_addr", 32'(avm_address) | avm_writedata | 32'(first_err_addr), 32'd0);
        chk("rst_be_clken", {27'd0, avm_byteenable, avm_clken}, 32'h1F);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_test(tbl[i]);
            if (i == 0) begin
                chk("wr3_count", 32'(wr3.size()), 32'd2);
                if (wr3.size() == 2) begin
                    chk("wr3_pass0", wr3[0], 32'hA5A50003);
                    chk("wr3_pass1", wr3[1], 32'h5A5AFFFC);
                end
            end
        end

        // abort on 5th write cycle
        fault = 0;
        push_writes(32'hA5A50000);
        @(negedge clk);
        start = 1'b1; seed = 32'hA5A50000;
        bc = 0;
        for (int c = 0; c < 50 && bc < 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) bc++;
        end
        chk("abort_reach_wr5", 32'(bc), 32'd5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_cs", {31'd0, avm_chipselect}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_pass", {31'd0, pass}, 32'd0);
        dc = 0;
        repeat (80) begin
            @(negedge clk);
            if (done || busy) dc++;
        end
        chk("abort_no_done", 32'(dc), 32'd0);
        exp_wr.delete();

        // start together with abort in IDLE
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        bc = 0;
        repeat (5) begin
            if (busy) bc++;
            @(negedge clk);
        end
        chk("start_abort_idle", 32'(bc), 32'd0);

        // asynchronous reset mid-read
        push_writes(32'hA5A50000);
        @(negedge clk);
        start = 1'b1; seed = 32'hA5A50000;
        bc = 0;
        for (int c = 0; c < 60 && bc < 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) bc++;
        end
        chk("rst_reach_rd", {31'd0, avm_chipselect && !avm_write}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_bus", {busy, done, avm_chipselect, avm_write}, 32'd0);
        chk("async_rst_data", 32'(avm_address) | avm_writedata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        exp_wr.delete();
        dc = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) dc++;
        end
        chk("post_rst_idle", 32'(dc), 32'd0);
        run_test(tbl[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
